// File: rtl/fifo_rd_arbiter.sv
`timescale 1ns/1ps
// fifo_rd_arbiter: round-robin arbiter sharing one FIFO read port among NREQ
// burst consumers, tagging each returned word with requester id and a
// last-word marker.
//   r_clk, r_resetn        read-domain clock, async active-low reset
//   req, req_len           per-requester burst request and packed length-1
//   fifo_empty, fifo_rdata registered empty flag and read data from the FIFO
//   r_enbl                 FIFO read enable (combinational, READ state only)
//   gnt, busy              one-hot grant and busy, held for the whole burst
//   out_valid/data/id/last tagged read-data stream
module fifo_rd_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned BLEN_W = 4,
    localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     r_clk,
    input  logic                     r_resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BLEN_W-1:0]   req_len,
    input  logic                     fifo_empty,
    input  logic [DWIDTH-1:0]        fifo_rdata,
    output logic                     r_enbl,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     out_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     out_last
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    state_t              state;
    logic [IDW-1:0]      rr_ptr;
    logic [BLEN_W-1:0]   len_q;
    logic [BLEN_W-1:0]   issue_cnt;

    logic                any_req;
    logic [IDW-1:0]      pick;
    logic [IDW:0]        scan_sum;
    logic [IDW-1:0]      scan_idx;
    logic [NREQ-1:0]     pick_gnt;
    logic [BLEN_W-1:0]   pick_len;
    logic [IDW-1:0]      rr_next;

    // First set req bit scanning upward from rr_ptr with wrap (any NREQ).
    always_comb begin
        any_req  = 1'b0;
        pick     = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!any_req && req[scan_idx]) begin
                any_req = 1'b1;
                pick    = scan_idx;
            end
        end
    end

    // Decode the winner into a one-hot grant and select its length field.
    always_comb begin
        pick_gnt = '0;
        pick_len = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick == IDW'(j)) begin
                pick_gnt[j] = 1'b1;
                pick_len    = req_len[j*BLEN_W +: BLEN_W];
            end
        end
    end

    assign rr_next  = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);

    // Read only while in READ and the registered empty flag is clear.
    assign r_enbl   = (state == READ) && !fifo_empty;

    // Data returns one cycle after r_enbl, aligned with registered out_valid.
    assign out_data = fifo_rdata;

    // Control FSM and registered outputs.
    always_ff @(posedge r_clk or negedge r_resetn) begin
        if (!r_resetn) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_id    <= '0;
            rr_ptr    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
        end else begin
            out_valid <= r_enbl;
            out_last  <= r_enbl && (issue_cnt == len_q);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick_gnt;
                        busy      <= 1'b1;
                        len_q     <= pick_len;
                        out_id    <= pick;
                        issue_cnt <= '0;
                        rr_ptr    <= rr_next;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (r_enbl) begin
                        // Compare before increment so len = 2^BLEN_W-1 never wraps early.
                        issue_cnt <= issue_cnt + BLEN_W'(1);
                        if (issue_cnt == len_q) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
`timescale 1ns/1ps
// tb_fifo_rd_arbiter: directed self-checking bench for fifo_rd_arbiter with a
// simple FIFO read-side model (registered empty flag, data one cycle after read).
module tb_fifo_rd_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DWIDTH = 8;
    localparam int unsigned BLEN_W = 4;

    logic                    r_clk    = 1'b0;
    logic                    r_resetn = 1'b1;
    logic [NREQ-1:0]         req      = '0;
    logic [NREQ*BLEN_W-1:0]  req_len  = '0;
    logic                    fifo_empty;
    logic [DWIDTH-1:0]       fifo_rdata;
    logic                    r_enbl;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    out_valid;
    logic [DWIDTH-1:0]       out_data;
    logic [1:0]              out_id;
    logic                    out_last;

    int checks = 0;
    int errors = 0;

    fifo_rd_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BLEN_W(BLEN_W)) dut (
        .r_clk      (r_clk),
        .r_resetn   (r_resetn),
        .req        (req),
        .req_len    (req_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .r_enbl     (r_enbl),
        .gnt        (gnt),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last)
    );

    always #5 r_clk = ~r_clk;

    // FIFO model: initial block writes mem/wr_ptr, this block owns the read side.
    logic [7:0] mem [0:255];
    int  wr_ptr    = 0;
    int  rd_ptr    = 0;
    bit  flush_req = 1'b0;
    int  underflow = 0;

    always @(posedge r_clk) begin
        if (flush_req) begin
            rd_ptr     <= wr_ptr;
            fifo_empty <= 1'b1;
        end else begin
            if (r_enbl) begin
                if (fifo_empty) underflow <= underflow + 1;
                fifo_rdata <= mem[rd_ptr % 256];
                rd_ptr     <= rd_ptr + 1;
            end
            fifo_empty <= (wr_ptr <= rd_ptr + (r_enbl ? 1 : 0));
        end
    end

    // Output monitor: log every delivered word.
    logic [7:0] log_data [0:255];
    logic [1:0] log_id   [0:255];
    logic       log_last [0:255];
    int         log_n = 0;

    always @(negedge r_clk) begin
        if (r_resetn && out_valid && log_n < 256) begin
            log_data[log_n] = out_data;
            log_id[log_n]   = out_id;
            log_last[log_n] = out_last;
            log_n           = log_n + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
    endtask

    task automatic wait_gnt(output bit timed_out);
        int cyc = 0;
        while (gnt == '0 && cyc < 50) begin
            tick(1);
            cyc++;
        end
        timed_out = (gnt == '0);
    endtask

    task automatic wait_idle(output bit timed_out, output int en_cnt);
        int cyc = 0;
        en_cnt = 0;
        while (busy && cyc < 200) begin
            if (r_enbl) en_cnt++;
            tick(1);
            cyc++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        r_resetn = 1'b0;
        #2;
        checks++;
        if ({gnt, busy, r_enbl, out_valid, out_last, out_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b busy=%b r_enbl=%b out_valid=%b out_last=%b out_id=%0d required all 0",
                     gnt, busy, r_enbl, out_valid, out_last, out_id);
        end
        tick(2);
        r_resetn = 1'b1;
        tick(2);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b busy=%b required 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single_burst();
        bit to;
        int en;
        int s;
        flush_fifo();
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        tick(2);
        req_len[0 +: 4] = 4'd2;
        s = log_n;
        req = 4'b0001;
        tick(1);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant_latency: gnt=%b busy=%b required 0001/1", gnt, busy);
        end
        req = 4'b0000;
        wait_idle(to, en);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL single_timeout: busy=%b required 0", busy);
        end
        checks++;
        if (en != 3) begin
            errors++;
            $display("FAIL single_renbl_count: got %0d required 3", en);
        end
        checks++;
        if (log_n - s != 3) begin
            errors++;
            $display("FAIL single_word_count: got %0d required 3", log_n - s);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_data[s+i] !== 8'hA0 + 8'(i) || log_id[s+i] !== 2'd0 || log_last[s+i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL single_word%0d: data=%h id=%0d last=%b required data=%h id=0 last=%b",
                             i, log_data[s+i], log_id[s+i], log_last[s+i], 8'hA0 + 8'(i), (i == 2));
                end
            end
        end
        checks++;
        if (gnt !== '0) begin
            errors++;
            $display("FAIL single_gnt_release: gnt=%b required 0000", gnt);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 2};
        logic [3:0] exp_g;
        bit to;
        int en;
        int s;
        r_resetn = 1'b0;
        tick(1);
        r_resetn = 1'b1;
        flush_fifo();
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        tick(2);
        req_len = '0;
        s = log_n;
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req = 4'b0101;
            wait_gnt(to);
            exp_g = '0;
            exp_g[order[i]] = 1'b1;
            checks++;
            if (to || gnt !== exp_g) begin
                errors++;
                $display("FAIL rr_grant%0d: gnt=%b required %b", i, gnt, exp_g);
            end
            req[order[i]] = 1'b0;
            wait_idle(to, en);
            checks++;
            if (to || en != 1) begin
                errors++;
                $display("FAIL rr_burst%0d: timeout=%b r_enbl count=%0d required 0/1", i, to, en);
            end
        end
        checks++;
        if (log_n - s != 6) begin
            errors++;
            $display("FAIL rr_word_count: got %0d required 6", log_n - s);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_id[s+i] !== 2'(order[i]) || log_last[s+i] !== 1'b1 || log_data[s+i] !== 8'h50 + 8'(i)) begin
                    errors++;
                    $display("FAIL rr_word%0d: id=%0d last=%b data=%h required id=%0d last=1 data=%h",
                             i, log_id[s+i], log_last[s+i], log_data[s+i], order[i], 8'h50 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        int en;
        int s;
        int en_stall = 0;
        flush_fifo();
        push(8'hB0);
        push(8'hB1);
        tick(2);
        req_len[4 +: 4] = 4'd3;
        s = log_n;
        req = 4'b0010;
        wait_gnt(to);
        checks++;
        if (to || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL stall_grant: gnt=%b required 0010", gnt);
        end
        req = 4'b0000;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            if (r_enbl) en_stall++;
            tick(1);
        end
        checks++;
        if (en_stall != 0 || busy !== 1'b1 || log_n - s != 2) begin
            errors++;
            $display("FAIL stall_hold: r_enbl pulses=%0d busy=%b words=%0d required 0/1/2",
                     en_stall, busy, log_n - s);
        end
        push(8'hB2);
        push(8'hB3);
        wait_idle(to, en);
        checks++;
        if (to || en != 2) begin
            errors++;
            $display("FAIL stall_resume: timeout=%b r_enbl count=%0d required 0/2", to, en);
        end
        checks++;
        if (log_n - s != 4) begin
            errors++;
            $display("FAIL stall_word_count: got %0d required 4", log_n - s);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_data[s+i] !== 8'hB0 + 8'(i) || log_id[s+i] !== 2'd1 || log_last[s+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL stall_word%0d: data=%h id=%0d last=%b required data=%h id=1 last=%b",
                             i, log_data[s+i], log_id[s+i], log_last[s+i], 8'hB0 + 8'(i), (i == 3));
                end
            end
        end
    endtask

    task automatic test_long_burst();
        bit to;
        int en;
        int s;
        int last_cnt = 0;
        int bad_data = 0;
        flush_fifo();
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
        tick(2);
        req_len[0 +: 4] = 4'd15;
        s = log_n;
        req = 4'b0001;
        wait_gnt(to);
        checks++;
        if (to || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL long_grant: gnt=%b required 0001", gnt);
        end
        req = 4'b0000;
        wait_idle(to, en);
        checks++;
        if (to || en != 16) begin
            errors++;
            $display("FAIL long_renbl_count: timeout=%b count=%0d required 0/16", to, en);
        end
        checks++;
        if (log_n - s != 16) begin
            errors++;
            $display("FAIL long_word_count: got %0d required 16", log_n - s);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (log_last[s+i]) last_cnt++;
                if (log_data[s+i] !== 8'hC0 + 8'(i)) bad_data++;
            end
            checks++;
            if (last_cnt != 1 || log_last[s+15] !== 1'b1 || bad_data != 0) begin
                errors++;
                $display("FAIL long_last_data: last count=%0d last on 16th=%b bad data=%0d required 1/1/0",
                         last_cnt, log_last[s+15], bad_data);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int en;
        int s2;
        int vcnt = 0;
        flush_fifo();
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        tick(2);
        req_len[8 +: 4] = 4'd5;
        req_len[0 +: 4] = 4'd0;
        req = 4'b0100;
        wait_gnt(to);
        checks++;
        if (to || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_grant: gnt=%b required 0100", gnt);
        end
        req = 4'b0000;
        tick(2);
        r_resetn = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, r_enbl, out_valid, out_last, out_id} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: gnt=%b busy=%b r_enbl=%b out_valid=%b out_last=%b out_id=%0d required all 0",
                     gnt, busy, r_enbl, out_valid, out_last, out_id);
        end
        tick(2);
        r_resetn = 1'b1;
        s2 = log_n;
        for (int i = 0; i < 5; i++) begin
            if (out_valid || gnt != '0) vcnt++;
            tick(1);
        end
        checks++;
        if (vcnt != 0 || log_n != s2) begin
            errors++;
            $display("FAIL rst_mid_quiet: active cycles=%0d words=%0d required 0/0", vcnt, log_n - s2);
        end
        req = 4'b1101;
        wait_gnt(to);
        checks++;
        if (to || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_regrant: gnt=%b required 0001", gnt);
        end
        req = 4'b0000;
        wait_idle(to, en);
        checks++;
        if (to || log_n - s2 != 1 || log_data[s2] !== 8'hD2 || log_id[s2] !== 2'd0 || log_last[s2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_word: timeout=%b words=%0d data=%h id=%0d last=%b required 0/1/d2/0/1",
                     to, log_n - s2, log_data[s2], log_id[s2], log_last[s2]);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int en;
        int s;
        flush_fifo();
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        tick(2);
        req_len[8 +: 4]  = 4'd1;
        req_len[12 +: 4] = 4'd0;
        s = log_n;
        req = 4'b0100;
        wait_gnt(to);
        checks++;
        if (to || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_grant2: gnt=%b required 0100", gnt);
        end
        req = 4'b1000;
        tick(3);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: gnt=%b busy=%b required 0000/0", gnt, busy);
        end
        tick(1);
        checks++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_grant3: gnt=%b busy=%b required 1000/1", gnt, busy);
        end
        req = 4'b0000;
        wait_idle(to, en);
        checks++;
        if (to || log_n - s != 3) begin
            errors++;
            $display("FAIL b2b_word_count: timeout=%b words=%0d required 0/3", to, log_n - s);
        end else begin
            checks++;
            if (log_data[s] !== 8'hE0 || log_id[s] !== 2'd2 || log_last[s] !== 1'b0 ||
                log_data[s+1] !== 8'hE1 || log_id[s+1] !== 2'd2 || log_last[s+1] !== 1'b1 ||
                log_data[s+2] !== 8'hE2 || log_id[s+2] !== 2'd3 || log_last[s+2] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_words: got %h/%0d/%b %h/%0d/%b %h/%0d/%b required e0/2/0 e1/2/1 e2/3/1",
                         log_data[s], log_id[s], log_last[s], log_data[s+1], log_id[s+1], log_last[s+1],
                         log_data[s+2], log_id[s+2], log_last[s+2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_long_burst();
        test_reset_mid_burst();
        test_back_to_back();
        checks++;
        if (underflow != 0) begin
            errors++;
            $display("FAIL fifo_underflow: reads while empty=%0d required 0", underflow);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin read-port arbiter for the async FIFO read domain.
- Shares the single FIFO read port (r_enbl / empty flag / read data) between NREQ consumers.
- Each consumer requests a burst of words. The block grants one requester at a time and issues r_enbl only while the FIFO is non-empty.
- Returned words are tagged with requester id and a last-word marker.
- Sits between read_ptr_block and the read-domain consumers; clocked entirely on r_clk.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 8, FIFO data width.
- BLEN_W, 4, burst-length field width per requester; burst = req_len+1 words (1..2^BLEN_W).

Ports:
- r_clk  input  1  read-domain clock.
- r_resetn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester burst request; level, held until matching gnt bit seen.
- req_len  input  NREQ*BLEN_W  packed burst lengths; field i = bits [i*BLEN_W +: BLEN_W]; sampled at grant.
- fifo_empty  input  1  registered empty flag from FIFO read pointer block.
- fifo_rdata  input  DWIDTH  FIFO read data; valid the cycle after r_enbl accepted.
- r_enbl  output  1  FIFO read enable (to read pointer block).
- gnt  output  NREQ  one-hot grant, high for the whole burst.
- busy  output  1  high from grant until last word delivered.
- out_valid  output  1  read word valid.
- out_data  output  DWIDTH  read word (= fifo_rdata when out_valid).
- out_id  output  log2(NREQ) (min 1)  requester id of out_data.
- out_last  output  1  high with final word of burst.

Behaviour:
- Reset (async, r_resetn=0): state=IDLE, gnt=0, busy=0, r_enbl=0, out_valid=0, out_last=0, out_id=0, rr_ptr=0, word counters=0. Reset mid-burst abandons the burst; no word is output after reset deasserts until a new grant.
- States: IDLE, READ, FLUSH.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap.
  - Next edge: gnt[k]=1, busy=1, latch len=req_len[k], latch id=k, issue_cnt=0, go to READ.
  - rr_ptr := (k+1) mod NREQ.
  - Grant latency: 1 cycle after req seen.
- READ:
  - r_enbl = !fifo_empty (combinational from the registered empty flag and state). Never high when fifo_empty=1 or outside READ.
  - Each cycle with r_enbl=1: issue_cnt++.
  - When issue_cnt==len and r_enbl=1: next state FLUSH.
  - While fifo_empty=1: stall in READ indefinitely. No timeout.
- FLUSH: one cycle for the last data return; then gnt=0, busy=0, go to IDLE. At least 1 idle cycle between bursts; next grant can issue the cycle after returning to IDLE.
- Data path:
  - out_valid = r_enbl delayed 1 cycle (registered).
  - out_data = fifo_rdata.
  - out_id = latched id.
  - out_last = 1 on the out_valid cycle whose read was issued with issue_cnt==len.
  - Exactly len+1 out_valid pulses per grant.
- Counters: issue_cnt BLEN_W bits. len = 2^BLEN_W-1 is legal and must not overflow before compare.
- req dropped after grant: burst still completes. req rising while another requester is granted: queued, served by the round-robin order.
- Simultaneous req of all bits: service order k, k+1, … from rr_ptr. No requester starves; worst-case wait is NREQ-1 bursts.
- req_len changes after grant: ignored until the next grant to that requester.
- Width rules: out_id = id truncated to its port width. rr_ptr wraps modulo NREQ (non-power-of-2 NREQ supported).

Test Plan:
- Reset, FIFO holding 5 words, req=4'b0001, len0=2 -> gnt=0001 one cycle later; r_enbl 3 cycles; out_valid 3 pulses with out_id=0 and out_last on 3rd; busy drops after FLUSH.
- req=4'b1111 all len=0, FIFO holding 8 words -> grants in order 0,1,2,3, each 1 word; rr_ptr=0 afterwards; then req=4'b0101 -> grant 0 then 2.
- Grant to req1 len=3, FIFO empty after 2 reads, refilled 10 cycles later -> r_enbl=0 during empty; exactly 4 words with out_id=1 and out_last on the 4th.
- BLEN_W=4, len=15, FIFO holding 16 words -> 16 r_enbl pulses, no counter wrap, out_last only on word 16.
- r_resetn pulsed low mid-burst (after 2 of 6 words) -> all outputs 0 immediately; no out_valid after release until a new req; first new grant goes to requester 0.
- req2 deasserted the cycle after gnt[2], len=1 -> burst still delivers 2 words; req3 asserted during the burst is granted after FLUSH plus one IDLE cycle.
